channel_serializer: RTL and testbench
=====================================

// Module: channel_serializer
// PURPOSE
//   Downstream stage of the transmitter's channel byte muxer. Sequences the channel select 1..NUM_CH,
//   captures the registered byte the muxer returns, and sends each byte on a UART-framed serial line.
//   One start request produces one frame: byte of channel 1, then 2, ..., then NUM_CH.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 1
//   NUM_CH        3   channels per frame, sent in order 1..NUM_CH; legal range 1..15
//   MUX_LAT       2   cycles from channel change to valid mux_data sample (1 register stage + 1 margin)
// PORTS
//   clk        in   1  system clock, rising edge
//   arst       in   1  asynchronous reset, active-high
//   start      in   1  frame request; sampled only in IDLE
//   channel    out  4  channel select to muxer; 0 = none selected
//   mux_data   in   8  byte returned by muxer for current channel
//   tx         out  1  serial line, idle high
//   busy       out  1  high from the cycle after start is accepted until the frame ends
//   done       out  1  one-cycle pulse when the last stop bit completes
// BEHAVIOUR
//   Reset values: tx=1, channel=0, busy=0, done=0, FSM=IDLE, all counters 0. Reset is asynchronous,
//     so tx returns high immediately even mid-bit; no partial frame resumes after release.
//   All outputs registered. FSM: IDLE -> SELECT -> START_BIT -> DATA -> STOP -> (SELECT | IDLE).
//   IDLE: tx=1, channel=0. If start=1 at an edge: ch_cnt=1, channel=1, busy=1, go SELECT.
//   SELECT: hold channel; wait MUX_LAT cycles; on the last one latch mux_data into shift_reg,
//     go START_BIT.
//   START_BIT: tx=0 for CLKS_PER_BIT cycles.
//   DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit_cnt 0..7.
//   STOP: tx=1 for CLKS_PER_BIT cycles. At the end: if ch_cnt < NUM_CH then ch_cnt+1, channel=ch_cnt+1,
//     go SELECT; else channel=0, busy=0, done=1 for one cycle, go IDLE.
//   Timing per channel: MUX_LAT + 10*CLKS_PER_BIT cycles. Frame = NUM_CH*(MUX_LAT+10*CLKS_PER_BIT).
//     With defaults, busy is high for exactly 486 cycles.
//   No idle gap between channels: the stop bit of channel n is followed directly by SELECT for n+1
//     with tx held at 1.
//   start while busy: ignored, neither queued nor counted.
//   start high in the done cycle: FSM is already IDLE, so the request is accepted. The next frame's
//     busy rises one cycle after done.
//   start held high continuously: frames repeat back to back.
//   mux_data is sampled exactly once per channel, on the last SELECT cycle. Later changes to
//     mux_data do not affect the byte in flight.
//   Baud counter: 0..CLKS_PER_BIT-1 and wraps; a bit boundary is the cycle the counter equals
//     CLKS_PER_BIT-1. With CLKS_PER_BIT=1 each bit lasts one cycle.
//   Width rules: ch_cnt is 4 bits; baud counter is $clog2(CLKS_PER_BIT+1) bits; bit_cnt is 3 bits.
// STRUCTURE
//   Shared package transmitter_pkg holds:
//     - state enum {IDLE, SELECT, START_BIT, DATA, STOP}
//     - CH_NONE = 4'h0, CH_FIRST = 4'h1
//     - UART constants START_LVL = 1'b0, STOP_LVL = 1'b1, DATA_BITS = 8
//   One sub-module, bit_timer (params CLKS_PER_BIT; ports clk, arst, en, tick):
//     - free-running baud counter, cleared when en=0
//     - tick high on the last cycle of each bit
//   The FSM, channel counter and shift register stay in channel_serializer.
// TESTING
//   Bench instantiates the channel byte muxer with CLKS_PER_BIT=4 and a serial decoder model.
//   1. Reset: assert arst with start=1 -> tx=1, channel=0, busy=0, done=0 while reset is held.
//      Release -> still IDLE, with no frame until start rises.
//   2. Single frame: input_data=24'hC35A81, 1-cycle start -> decoder reads 0x81, 0x5A, 0xC3.
//      Channel sequence is 1,2,3,0. busy is high for 3*(2+40)=126 cycles; done pulses once.
//   3. start pulses at cycles 5, 40 and 100 of a frame -> ignored. Exactly one frame, one done pulse.
//   4. Reset mid-frame: arst during DATA bit 3 of channel 2 -> tx=1 and channel=0 in the same cycle.
//      After release, a new start sends a full 3-byte frame beginning with channel 1.
//   5. Back-to-back: start high in the done cycle -> second frame starts, busy rises the next cycle.
//      tx stays 1 between frames and the second frame's bytes are correct.
//   6. Corner cases:
//      - CLKS_PER_BIT=1, NUM_CH=1: frame is 12 cycles, only channel 1's byte is sent.
//      - input_data changed mid-byte: the byte in flight is unchanged.

Source files
------------

// File: rtl/transmitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : transmitter_pkg
// Description : Shared types and constants for the transmitter channel path:
//               serializer state encoding, channel select codes and UART
//               framing levels.
// Revision    : 1.0 - initial release
// ============================================================================
package transmitter_pkg;

   // Serializer sequencing states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SELECT    = 3'd1,
      START_BIT = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4
   } state_e;

   // Channel select codes driven to the muxer
   localparam logic [3:0] CH_NONE  = 4'h0;
   localparam logic [3:0] CH_FIRST = 4'h1;

   // UART framing
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam int   DATA_BITS = 8;

   // True for the states that put a timed bit on the line
   function automatic logic is_bit_state(input state_e s);
      return (s == START_BIT) || (s == DATA) || (s == STOP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/channel_serializer_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_timer
// Description : Baud counter for the serial line. Counts 0..CLKS_PER_BIT-1
//               while enabled and raises tick on the last cycle of each bit.
//               Held at zero whenever disabled so every bit period starts
//               aligned to the enable.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic arst,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;

   // Free-running baud counter, cleared while the line is not being timed
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt_q <= '0;
      end else if (!en) begin
         cnt_q <= '0;
      end else if (cnt_q == c_LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // With CLKS_PER_BIT=1 the counter stays at zero and tick follows en
   assign tick = en && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/channel_serializer.sv
`default_nettype none
// ============================================================================
// Module      : channel_serializer
// Description : Steps the muxer channel select through 1..NUM_CH, captures
//               the byte returned for each channel and sends it as a UART
//               frame (start, 8 data bits LSB first, stop). One start request
//               sends one byte per channel, back to back, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_serializer
   import transmitter_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int NUM_CH       = 3,
   parameter int MUX_LAT      = 2
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       start,
   output logic [3:0] channel,
   input  logic [7:0] mux_data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   // Select wait counter sized for 0..MUX_LAT-1
   localparam int LAT_W = (MUX_LAT > 1) ? $clog2(MUX_LAT) : 1;
   localparam logic [LAT_W-1:0] c_LAT_LAST = LAT_W'(MUX_LAT - 1);
   localparam logic [3:0]       c_NUM_CH   = 4'(NUM_CH);
   localparam logic [2:0]       c_BIT_LAST = 3'(DATA_BITS - 1);

   state_e           state_q, state_d;
   logic [3:0]       ch_cnt_q, ch_cnt_d;
   logic [3:0]       channel_q, channel_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             w_timer_en;
   logic             w_tick;

   // The baud counter only runs while a start, data or stop bit is on the line
   assign w_timer_en = is_bit_state(state_q);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk  (clk),
      .arst (arst),
      .en   (w_timer_en),
      .tick (w_tick)
   );

   // State and output registers; reset forces the line idle immediately
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= IDLE;
         ch_cnt_q  <= '0;
         channel_q <= CH_NONE;
         lat_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= STOP_LVL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_cnt_q  <= ch_cnt_d;
         channel_q <= channel_d;
         lat_q     <= lat_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   always_comb begin
      state_d   = state_q;
      ch_cnt_d  = ch_cnt_q;
      channel_d = channel_q;
      lat_d     = '0;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d      = STOP_LVL;
            channel_d = CH_NONE;
            if (start) begin
               ch_cnt_d  = CH_FIRST;
               channel_d = CH_FIRST;
               busy_d    = 1'b1;
               state_d   = SELECT;
            end
         end

         SELECT: begin
            // Give the muxer MUX_LAT cycles to present the new channel's byte
            if (lat_q == c_LAT_LAST) begin
               shift_d = mux_data;
               tx_d    = START_LVL;
               state_d = START_BIT;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end

         START_BIT: begin
            if (w_tick) begin
               tx_d      = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end

         DATA: begin
            if (w_tick) begin
               if (bit_cnt_q == c_BIT_LAST) begin
                  tx_d    = STOP_LVL;
                  state_d = STOP;
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

         STOP: begin
            if (w_tick) begin
               if (ch_cnt_q < c_NUM_CH) begin
                  // Next channel follows with the line still high
                  ch_cnt_d  = ch_cnt_q + 4'd1;
                  channel_d = ch_cnt_q + 4'd1;
                  state_d   = SELECT;
               end else begin
                  channel_d = CH_NONE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end
            end
         end

         default: begin
            state_d   = IDLE;
            tx_d      = STOP_LVL;
            channel_d = CH_NONE;
            busy_d    = 1'b0;
         end
      endcase
   end

   assign channel = channel_q;
   assign tx      = tx_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_serializer
// Description : Self-checking bench for channel_serializer. A registered
//               channel muxer and a UART line decoder surround the DUT; each
//               frame is compared cycle by cycle against a waveform built from
//               the framing rules, plus a second small instance with one
//               channel and one clock per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_serializer;

   localparam int CPB    = 4;
   localparam int NCH    = 3;
   localparam int MLAT   = 2;
   localparam int CH_CYC = MLAT + 10 * CPB;   // 42
   localparam int FRAME  = NCH * CH_CYC;      // 126

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        start = 1'b0;
   logic        start1 = 1'b0;
   logic [23:0] input_data = '0;
   logic [7:0]  input1 = '0;
   logic [3:0]  channel, channel1;
   logic [7:0]  mux_data, mux1;
   logic        tx, busy, done, tx1, busy1, done1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   channel_serializer #(.CLKS_PER_BIT(CPB), .NUM_CH(NCH), .MUX_LAT(MLAT)) dut (
      .clk(clk), .arst(arst), .start(start), .channel(channel),
      .mux_data(mux_data), .tx(tx), .busy(busy), .done(done));

   channel_serializer #(.CLKS_PER_BIT(1), .NUM_CH(1), .MUX_LAT(MLAT)) dut1 (
      .clk(clk), .arst(arst), .start(start1), .channel(channel1),
      .mux_data(mux1), .tx(tx1), .busy(busy1), .done(done1));

   // Channel byte muxers: one register stage
   always @(posedge clk or posedge arst) begin
      if (arst) mux_data <= 8'h00;
      else case (channel)
         4'd1:    mux_data <= input_data[7:0];
         4'd2:    mux_data <= input_data[15:8];
         4'd3:    mux_data <= input_data[23:16];
         default: mux_data <= 8'h00;
      endcase
   end

   always @(posedge clk or posedge arst) begin
      if (arst) mux1 <= 8'h00;
      else      mux1 <= (channel1 == 4'd1) ? input1 : 8'h00;
   end

   // UART decoder: mid-bit sampling, bytes with a valid stop bit are queued
   logic       rx_on;
   int         rx_off;
   logic [7:0] rx_sh;
   logic [7:0] rx_q[$];

   always @(negedge clk or posedge arst) begin
      if (arst) begin
         rx_on  <= 1'b0;
         rx_off <= 0;
      end else if (!rx_on) begin
         if (tx === 1'b0) begin
            rx_on  <= 1'b1;
            rx_off <= 1;
         end
      end else begin
         rx_off <= rx_off + 1;
         if (rx_off >= CPB + CPB/2 && rx_off <= 8*CPB + CPB/2 &&
             ((rx_off - CPB - CPB/2) % CPB) == 0)
            rx_sh <= {tx, rx_sh[7:1]};
         if (rx_off == 9*CPB + CPB/2) begin
            rx_on <= 1'b0;
            if (tx === 1'b1) rx_q.push_back(rx_sh);
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference waveform of one frame, from the framing rules
   function automatic logic model_tx(input int i, input logic [23:0] bytes);
      int seg, off;
      if (i >= FRAME) return 1'b1;
      seg = i / CH_CYC;
      off = i % CH_CYC;
      if (off < MLAT) return 1'b1;
      off = off - MLAT;
      if (off < CPB) return 1'b0;
      off = off - CPB;
      if (off < 8*CPB) return bytes[8*seg + off/CPB];
      return 1'b1;
   endfunction

   function automatic logic [3:0] model_ch(input int i);
      return (i < FRAME) ? 4'(i / CH_CYC + 1) : 4'd0;
   endfunction

   // Byte n is whatever input_data holds during that channel's select window
   function automatic logic [7:0] model_byte(input int n, input logic [23:0] d,
                                             input int chg_at, input logic [23:0] cd);
      if (chg_at >= 0 && chg_at < n * CH_CYC) return cd[8*n +: 8];
      return d[8*n +: 8];
   endfunction

   typedef struct {
      logic [23:0] data;
      int          p0, p1, p2;     // cycles carrying an ignored start pulse
      int          chg_at;         // cycle input_data changes, -1 none
      logic [23:0] chg_data;
      logic [7:0]  eb0, eb1, eb2;  // expected bytes for channels 1..3
      bit          chain;          // start held high in the done cycle
   } vec_t;

   // One frame; begins in IDLE (or already accepted when pre=1)
   task automatic do_frame(input vec_t v, input bit pre, input string tag);
      logic [FRAME:0] a_tx, e_tx, a_busy, e_busy, a_done, e_done;
      logic [23:0]    eb;
      int             chbad, nbusy;
      eb = {v.eb2, v.eb1, v.eb0};
      chbad = 0;
      nbusy = 0;
      rx_q.delete();
      input_data = v.data;
      if (!pre) begin
         @(posedge clk); #1 start = 1'b1;
      end
      @(posedge clk); #1;
      for (int i = 0; i <= FRAME; i++) begin
         start = (i == v.p0) || (i == v.p1) || (i == v.p2) || (v.chain && i == FRAME);
         if (i == v.chg_at) input_data = v.chg_data;
         @(negedge clk);
         a_tx[i]   = tx;
         a_busy[i] = busy;
         a_done[i] = done;
         e_tx[i]   = model_tx(i, eb);
         e_busy[i] = (i < FRAME);
         e_done[i] = (i == FRAME);
         if (channel !== model_ch(i)) chbad++;
         if (busy === 1'b1) nbusy++;
         if (i < FRAME) begin
            @(posedge clk); #1;
         end
      end
      chk({tag, " tx waveform"}, 128'(a_tx), 128'(e_tx));
      chk({tag, " busy waveform"}, 128'(a_busy), 128'(e_busy));
      chk({tag, " busy cycles"}, 128'(nbusy), 128'(FRAME));
      chk({tag, " done pulse"}, 128'(a_done), 128'(e_done));
      chk({tag, " channel bad cycles"}, 128'(chbad), 128'd0);
      chk({tag, " rx byte count"}, 128'(rx_q.size()), 128'd3);
      for (int n = 0; n < 3; n++)
         chk({tag, " rx byte"}, (rx_q.size() > n) ? 128'(rx_q[n]) : 128'hdead,
             128'(eb[8*n +: 8]));
   endtask

   // One frame on the one-channel, one-clock-per-bit instance
   task automatic small_frame(input logic [7:0] b, input string tag);
      logic [12:0] a_tx, e_tx, a_busy, e_busy, a_done, e_done;
      int          chbad;
      chbad = 0;
      input1 = b;
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      for (int i = 0; i <= 12; i++) begin
         if (i == 5) input1 = ~b;
         @(negedge clk);
         a_tx[i]   = tx1;
         a_busy[i] = busy1;
         a_done[i] = done1;
         e_tx[i]   = (i == 2) ? 1'b0 : (i >= 3 && i <= 10) ? b[i-3] : 1'b1;
         e_busy[i] = (i < 12);
         e_done[i] = (i == 12);
         if (channel1 !== ((i < 12) ? 4'd1 : 4'd0)) chbad++;
         if (i < 12) begin
            @(posedge clk); #1;
         end
      end
      chk({tag, " tx"}, 128'(a_tx), 128'(e_tx));
      chk({tag, " busy"}, 128'(a_busy), 128'(e_busy));
      chk({tag, " done"}, 128'(a_done), 128'(e_done));
      chk({tag, " channel bad cycles"}, 128'(chbad), 128'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      vec_t rv;
      bit   pre;
      int   c, idle_bad;

      tbl[0] = '{24'hC35A81, -1, -1, -1, -1, 24'h0, 8'h81, 8'h5A, 8'hC3, 1'b0};
      tbl[1] = '{24'h00FF00,  5, 40, 100, -1, 24'h0, 8'h00, 8'hFF, 8'h00, 1'b0};
      tbl[2] = '{24'h123456, -1, -1, -1, 20, 24'hABCDEF, 8'h56, 8'hCD, 8'hAB, 1'b1};
      tbl[3] = '{24'h5AA5F0, -1, -1, -1, -1, 24'h0, 8'hF0, 8'hA5, 8'h5A, 1'b0};
      tbl[4] = '{24'hFFFFFF, 30, -1, -1, 70, 24'h000000, 8'hFF, 8'hFF, 8'h00, 1'b0};

      // Reset held with start high
      start = 1'b1;
      start1 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset tx", 128'(tx), 128'd1);
      chk("reset channel", 128'(channel), 128'd0);
      chk("reset busy", 128'(busy), 128'd0);
      chk("reset done", 128'(done), 128'd0);
      chk("reset small tx", 128'(tx1), 128'd1);
      start = 1'b0;
      start1 = 1'b0;
      @(posedge clk); #1 arst = 1'b0;
      idle_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || channel !== 4'd0 || done !== 1'b0) idle_bad++;
      end
      chk("idle after release bad cycles", 128'(idle_bad), 128'd0);

      // Table of frames; a chained entry hands its accepted start to the next
      pre = 1'b0;
      for (int k = 0; k < 5; k++) begin
         do_frame(tbl[k], pre, $sformatf("vec%0d", k));
         pre = tbl[k].chain;
      end

      // Reset during DATA bit 3 of channel 2
      rx_q.delete();
      input_data = 24'h3C96E1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (61) @(posedge clk);
      @(negedge clk);
      chk("midreset pre tx", 128'(tx), 128'd0);
      chk("midreset pre channel", 128'(channel), 128'd2);
      #2 arst = 1'b1;
      #1;
      chk("midreset tx", 128'(tx), 128'd1);
      chk("midreset channel", 128'(channel), 128'd0);
      chk("midreset busy", 128'(busy), 128'd0);
      repeat (3) @(posedge clk);
      #1 arst = 1'b0;
      do_frame('{24'h3C96E1, -1, -1, -1, -1, 24'h0, 8'hE1, 8'h96, 8'h3C, 1'b0},
               1'b0, "after reset");

      // Randomized frames against the model
      for (int r = 0; r < 6; r++) begin
         rv.data  = 24'($urandom);
         rv.p0    = $urandom_range(0, 1) ? int'($urandom_range(1, FRAME - 1)) : -1;
         rv.p1    = $urandom_range(0, 1) ? int'($urandom_range(1, FRAME - 1)) : -1;
         rv.p2    = -1;
         rv.chg_data = 24'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            c = $urandom_range(0, NCH - 1);
            rv.chg_at = c * CH_CYC + MLAT + CPB + int'($urandom_range(0, 8*CPB - 1));
         end else begin
            rv.chg_at = -1;
         end
         rv.eb0   = model_byte(0, rv.data, rv.chg_at, rv.chg_data);
         rv.eb1   = model_byte(1, rv.data, rv.chg_at, rv.chg_data);
         rv.eb2   = model_byte(2, rv.data, rv.chg_at, rv.chg_data);
         rv.chain = 1'b0;
         do_frame(rv, 1'b0, $sformatf("rand%0d", r));
      end

      // One channel, one clock per bit
      small_frame(8'hB4, "small B4");
      small_frame(8'($urandom), "small rand");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
